ifu_fetch_rsp: RTL and testbench



---
 rtl/ifu_fetch_rsp_if.sv | 57 +++++
 rtl/ifu_fetch_rsp.sv | 177 +++++++++++++++++
 tb/tb_ifu_fetch_rsp.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_rsp_if.sv
// Fetch bus between the IFU, the fetch-response block and the instruction
// SRAM. The slave side is the fetch-response block. The master side is the
// IFU together with the SRAM model.
interface ifu_fetch_rsp_if #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int MEM_AW     = 12
);

  // IFU request channel
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [PC_SIZE-1:0]    ifu_req_pc;

  // IFU response channel
  logic                  ifu_rsp_valid;
  logic                  ifu_rsp_ready;
  logic                  ifu_rsp_err;
  logic [INSTR_SIZE-1:0] ifu_rsp_instr;

  // Instruction SRAM read port
  logic                  mem_cs;
  logic [MEM_AW-1:0]     mem_addr;
  logic [INSTR_SIZE-1:0] mem_rdata;

  // Idle indication
  logic                  no_outs;

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_pc,
    output ifu_req_ready,
    output ifu_rsp_valid,
    input  ifu_rsp_ready,
    output ifu_rsp_err,
    output ifu_rsp_instr,
    output mem_cs,
    output mem_addr,
    input  mem_rdata,
    output no_outs
  );

  modport master (
    output ifu_req_valid,
    output ifu_req_pc,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    output ifu_rsp_ready,
    input  ifu_rsp_err,
    input  ifu_rsp_instr,
    input  mem_cs,
    input  mem_addr,
    output mem_rdata,
    input  no_outs
  );

endinterface

// File: rtl/ifu_fetch_rsp.sv
// Instruction fetch response block.
// A request with a legal PC fires a single-cycle SRAM read. A request with
// an illegal PC fires no read and is flagged as an error. Each accepted
// request occupies a one-entry in-flight stage for one cycle. It then
// drops into a 2-entry in-order response FIFO.
// The FIFO falls through when it is empty. The in-flight entry is visible
// on the response port in the cycle after the request handshake. If that
// entry is accepted in the same cycle, it is never written into storage.
// Request acceptance depends on registered occupancy only. The FIFO
// therefore can never overflow.
module ifu_fetch_rsp #(
  parameter int                 PC_SIZE    = 32,
  parameter int                 INSTR_SIZE = 32,
  parameter int                 MEM_AW     = 12,
  parameter logic [PC_SIZE-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  ifu_fetch_rsp_if.slave fetch
);

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic [PC_SIZE-1:0]    pc_off;
  logic                  unused_pc_off;
  logic                  pc_legal;
  logic [1:0]            occ;
  logic                  req_rdy;
  logic                  req_hs;

  logic                  inflt_vld_q;
  logic                  inflt_vld_d;
  logic                  inflt_err_q;
  logic                  inflt_err_d;

  logic [1:0]            cnt_q;
  logic [1:0]            cnt_d;
  logic                  wr_ptr_q;
  logic                  wr_ptr_d;
  logic                  rd_ptr_q;
  logic                  rd_ptr_d;
  logic                  fifo_err_q  [2];
  logic [INSTR_SIZE-1:0] fifo_data_q [2];

  logic                  fifo_empty;
  logic                  push;
  logic                  push_err;
  logic [INSTR_SIZE-1:0] push_data;
  logic                  rsp_vld;
  logic                  head_err;
  logic [INSTR_SIZE-1:0] head_data;
  logic                  pop;
  logic                  pop_stored;
  logic                  store;

  // ---------------------------------------------------------------------
  // Request side: address check and SRAM strobe
  // ---------------------------------------------------------------------
  // Modular subtraction: PCs below the base wrap to a huge offset and
  // fail the range check. A separate lower-bound compare is not needed.
  assign pc_off   = fetch.ifu_req_pc - BASE_ADDR;
  assign pc_legal = (fetch.ifu_req_pc[1:0] == 2'b00) &&
                    (pc_off[PC_SIZE-1:MEM_AW+2] == '0);

  // The byte-offset bits of pc_off carry no word-address information.
  assign unused_pc_off = ^pc_off[1:0];

  // Occupancy counts the buffered responses plus the one in flight.
  assign occ     = cnt_q + {1'b0, inflt_vld_q};

  // Ready comes from registered state only. ifu_rsp_ready has no
  // combinational path to it.
  assign req_rdy = (occ < 2'd2);

  // No handshake is taken while reset is held. The SRAM strobe is
  // therefore quiet during reset.
  assign req_hs  = fetch.ifu_req_valid & req_rdy & ~rst;

  assign fetch.ifu_req_ready = req_rdy;
  assign fetch.mem_cs        = req_hs & pc_legal;
  assign fetch.mem_addr      = pc_off[MEM_AW+1:2];

  // ---------------------------------------------------------------------
  // In-flight stage to FIFO: the entry pushed this cycle
  // ---------------------------------------------------------------------
  // SRAM data is valid in the cycle after mem_cs.
  // Error entries carry an all-zero instruction.
  assign push      = inflt_vld_q;
  assign push_err  = inflt_err_q;
  assign push_data = inflt_err_q ? '0 : fetch.mem_rdata;

  // ---------------------------------------------------------------------
  // Response side: fall-through head selection and pop
  // ---------------------------------------------------------------------
  assign fifo_empty = (cnt_q == 2'd0);
  assign rsp_vld    = ~fifo_empty | push;
  assign head_err   = fifo_empty ? push_err  : fifo_err_q[rd_ptr_q];
  assign head_data  = fifo_empty ? push_data : fifo_data_q[rd_ptr_q];

  assign pop        = rsp_vld & fetch.ifu_rsp_ready;
  assign pop_stored = pop & ~fifo_empty;

  // A push into an empty FIFO that is popped in the same cycle bypasses
  // storage entirely.
  assign store      = push & ~(fifo_empty & pop);

  // Outputs are masked to zero when nothing is valid. Reset then shows
  // clean zeros without having to reset the data storage.
  assign fetch.ifu_rsp_valid = rsp_vld;
  assign fetch.ifu_rsp_err   = rsp_vld & head_err;
  assign fetch.ifu_rsp_instr = rsp_vld ? head_data : '0;
  assign fetch.no_outs       = (occ == 2'd0);

  // Next-state logic for the in-flight stage, the FIFO count and the pointers.
  always_comb begin
    inflt_vld_d = 1'b0;
    inflt_err_d = 1'b0;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    // A new handshake reloads the in-flight stage in the same cycle that
    // the previous entry leaves it.
    if (req_hs) begin
      inflt_vld_d = 1'b1;
      inflt_err_d = ~pc_legal;
    end

    // Simultaneous store and stored-pop leaves the count unchanged.
    cnt_d = cnt_q + {1'b0, store} - {1'b0, pop_stored};

    if (store) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop_stored) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Control state register. Reset discards all in-flight and buffered
  // responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflt_vld_q <= 1'b0;
      inflt_err_q <= 1'b0;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      inflt_vld_q <= inflt_vld_d;
      inflt_err_q <= inflt_err_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Response storage write. Data is not reset because it is masked by
  // the valid signal.
  always_ff @(posedge clk) begin
    if (store) begin
      fifo_err_q[wr_ptr_q]  <= push_err;
      fifo_data_q[wr_ptr_q] <= push_data;
    end
  end

  // Invariants: the ready rule forbids a store into a full FIFO, and
  // occupancy never exceeds 2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(store && (cnt_q == 2'd2)));
      assert (occ != 2'd3);
    end
  end

endmodule

// File: tb/tb_ifu_fetch_rsp.sv
// Self-checking bench for ifu_fetch_rsp. It keeps a queue-level model of
// outstanding responses, compared every cycle, plus directed literal
// expectations.
module tb_ifu_fetch_rsp;

  localparam int          PC_SIZE    = 32;
  localparam int          INSTR_SIZE = 32;
  localparam int          MEM_AW     = 12;
  localparam logic [31:0] BASE       = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ifu_fetch_rsp_if #(
    .PC_SIZE   (PC_SIZE),
    .INSTR_SIZE(INSTR_SIZE),
    .MEM_AW    (MEM_AW)
  ) bus ();

  ifu_fetch_rsp #(
    .PC_SIZE   (PC_SIZE),
    .INSTR_SIZE(INSTR_SIZE),
    .MEM_AW    (MEM_AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .fetch(bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // SRAM contents: word 4 holds 0x13, every other word holds 0xA500_0000 | index.
  function automatic logic [31:0] word_of(input int idx);
    return (idx == 4) ? 32'h0000_0013 : (32'hA500_0000 | 32'(idx));
  endfunction

  logic [31:0] sram [0:4095];

  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = word_of(i);
  end

  // SRAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_cs) bus.mem_rdata <= sram[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Model legality: word aligned and inside [BASE, BASE + 16 KiB).
  function automatic bit model_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc >= BASE) && (pc < BASE + 32'h0000_4000);
  endfunction

  // Model state: the ordered list of accepted responses not yet consumed
  // by the IFU. Each entry is {err, instr}.
  logic [32:0] rsp_q [$];
  bit          m_ready;
  bit          m_hs;
  bit          m_legal;

  // Per-cycle compare against the model, then advance it across the next edge.
  always @(negedge clk) begin
    if (rst) begin
      rsp_q.delete();
      chk("rst_req_ready", bus.ifu_req_ready, 1);
      chk("rst_rsp_valid", bus.ifu_rsp_valid, 0);
      chk("rst_rsp_err",   bus.ifu_rsp_err,   0);
      chk("rst_rsp_instr", bus.ifu_rsp_instr, 0);
      chk("rst_mem_cs",    bus.mem_cs,        0);
      chk("rst_no_outs",   bus.no_outs,       1);
    end else begin
      m_ready = (rsp_q.size() < 2);
      m_hs    = bus.ifu_req_valid && m_ready;
      m_legal = model_legal(bus.ifu_req_pc);
      chk("mdl_req_ready", bus.ifu_req_ready, m_ready);
      chk("mdl_mem_cs",    bus.mem_cs, m_hs && m_legal);
      if (m_hs && m_legal)
        chk("mdl_mem_addr", bus.mem_addr, (bus.ifu_req_pc - BASE) >> 2);
      chk("mdl_no_outs",   bus.no_outs, rsp_q.size() == 0);
      chk("mdl_rsp_valid", bus.ifu_rsp_valid, rsp_q.size() != 0);
      if (rsp_q.size() != 0) begin
        chk("mdl_rsp_err",   bus.ifu_rsp_err,   rsp_q[0][32]);
        chk("mdl_rsp_instr", bus.ifu_rsp_instr, rsp_q[0][31:0]);
      end
      if (rsp_q.size() != 0 && bus.ifu_rsp_ready) void'(rsp_q.pop_front());
      if (m_hs) begin
        if (m_legal) rsp_q.push_back({1'b0, word_of(int'((bus.ifu_req_pc - BASE) >> 2))});
        else         rsp_q.push_back({1'b1, 32'h0});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream_exp [8];

  initial begin
    stream_exp = '{32'hA500_0000, 32'hA500_0001, 32'hA500_0002, 32'hA500_0003,
                   32'h0000_0013, 32'hA500_0005, 32'hA500_0006, 32'hA500_0007};

    // Reset: a request is held valid and must be ignored.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_pc    = 32'h8000_0010;
    bus.ifu_rsp_ready = 1'b1;
    @(negedge clk);
    chk("lit_reset_mem_cs",    bus.mem_cs,        0);
    chk("lit_reset_ready",     bus.ifu_req_ready, 1);
    chk("lit_reset_rsp_valid", bus.ifu_rsp_valid, 0);
    chk("lit_reset_no_outs",   bus.no_outs,       1);
    cyc();
    rst = 1'b0;

    // Single fetch of word 4, accepted in the first cycle out of reset.
    @(negedge clk);
    chk("lit_single_mem_cs",   bus.mem_cs,   1);
    chk("lit_single_mem_addr", bus.mem_addr, 4);
    cyc();
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("lit_single_rsp_valid", bus.ifu_rsp_valid, 1);
    chk("lit_single_instr",     bus.ifu_rsp_instr, 32'h0000_0013);
    chk("lit_single_err",       bus.ifu_rsp_err,   0);
    cyc();

    // Misaligned PC.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_pc    = 32'h8000_0002;
    @(negedge clk);
    chk("lit_misal_mem_cs", bus.mem_cs, 0);
    cyc();
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("lit_misal_rsp_valid", bus.ifu_rsp_valid, 1);
    chk("lit_misal_err",       bus.ifu_rsp_err,   1);
    chk("lit_misal_instr",     bus.ifu_rsp_instr, 0);
    cyc();

    // Out of range above and below the window, back to back.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_pc    = 32'h8000_4000;
    @(negedge clk);
    chk("lit_oor_hi_mem_cs", bus.mem_cs, 0);
    cyc();
    bus.ifu_req_pc = 32'h7FFF_FFFC;
    @(negedge clk);
    chk("lit_oor_hi_err",    bus.ifu_rsp_err, 1);
    chk("lit_oor_lo_mem_cs", bus.mem_cs,      0);
    cyc();
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("lit_oor_lo_valid", bus.ifu_rsp_valid, 1);
    chk("lit_oor_lo_err",   bus.ifu_rsp_err,   1);
    cyc();

    // Backpressure: two requests accepted, the third is blocked until the
    // IFU drains.
    bus.ifu_rsp_ready = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_pc    = 32'h8000_0000;
    @(negedge clk);
    chk("lit_bp_ready0", bus.ifu_req_ready, 1);
    cyc();
    bus.ifu_req_pc = 32'h8000_0004;
    @(negedge clk);
    chk("lit_bp_ready1", bus.ifu_req_ready, 1);
    chk("lit_bp_head1",  bus.ifu_rsp_instr, 32'hA500_0000);
    cyc();
    bus.ifu_req_pc = 32'h8000_0008;
    @(negedge clk);
    chk("lit_bp_blocked", bus.ifu_req_ready, 0);
    chk("lit_bp_busy",    bus.no_outs,       0);
    chk("lit_bp_stable",  bus.ifu_rsp_instr, 32'hA500_0000);
    cyc();
    bus.ifu_rsp_ready = 1'b1;
    @(negedge clk);
    chk("lit_bp_still_blocked", bus.ifu_req_ready, 0);
    chk("lit_bp_word0",         bus.ifu_rsp_instr, 32'hA500_0000);
    cyc();
    @(negedge clk);
    chk("lit_bp_third_ready", bus.ifu_req_ready, 1);
    chk("lit_bp_word1",       bus.ifu_rsp_instr, 32'hA500_0001);
    cyc();
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("lit_bp_word2", bus.ifu_rsp_instr, 32'hA500_0002);
    cyc();
    @(negedge clk);
    chk("lit_bp_idle", bus.no_outs, 1);
    cyc();

    // Streaming: 8 sequential PCs, one response per cycle.
    for (int i = 0; i < 8; i++) begin
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_pc    = BASE + 32'(4 * i);
      @(negedge clk);
      if (i > 0) begin
        chk("lit_stream_valid", bus.ifu_rsp_valid, 1);
        chk("lit_stream_instr", bus.ifu_rsp_instr, stream_exp[i-1]);
      end
      cyc();
    end
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("lit_stream_last", bus.ifu_rsp_instr, stream_exp[7]);
    cyc();
    @(negedge clk);
    chk("lit_stream_no_outs", bus.no_outs,       1);
    chk("lit_stream_drained", bus.ifu_rsp_valid, 0);
    cyc();

    // Reset mid-flight with two responses buffered.
    bus.ifu_rsp_ready = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_pc    = 32'h8000_0000;
    cyc();
    bus.ifu_req_pc = 32'h8000_0004;
    cyc();
    bus.ifu_req_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("lit_rstmid_buffered", bus.ifu_req_ready, 0);
    cyc();
    rst = 1'b1;
    #1;
    chk("lit_rstmid_valid",   bus.ifu_rsp_valid, 0);
    chk("lit_rstmid_no_outs", bus.no_outs,       1);
    cyc();
    rst = 1'b0;
    bus.ifu_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_rstmid_no_stale", bus.ifu_rsp_valid, 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
